// File: rtl/procfix_pkg.sv
// rtl/procfix_pkg.sv - shared request/output codes and width helper for the sample FIFO
package procfix_pkg;

    // Source request codes driven on req_in
    localparam logic [1:0] REQ_IDLE      = 2'd0;
    localparam logic [1:0] REQ_SAMPLE    = 2'd1;

    // Output qualifier codes driven on out_en
    localparam logic [1:0] OUT_NONE      = 2'd0;
    localparam logic [1:0] OUT_SAMPLE    = 2'd1;
    localparam logic [1:0] OUT_FRAME_END = 2'd2;

    // Channel tag width; a single channel still carries a 1-bit tag
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/procfix_fifo_mem.sv
// rtl/procfix_fifo_mem.sv - DEPTH x WIDTH storage, one synchronous write port, one synchronous read port
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears the read register only)
//   we, waddr, wdata   write port, entry written at the rising edge when we = 1
//   re, raddr, rdata   read port, rdata loads mem[raddr] at the rising edge when re = 1, else holds
module procfix_fifo_mem
    import procfix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds between reads, which gives the output its hold behaviour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/procfix_sample_fifo.sv
// rtl/procfix_sample_fifo.sv - request-driven sample FIFO with interleaved channel tagging
// Ports:
//   clk, rst   single clock, asynchronous active-high reset
//   in         signed sample from source, valid the cycle after req_in = REQ_SAMPLE
//   req_in     registered source request code (REQ_IDLE / REQ_SAMPLE)
//   rd_ready   downstream accepts one sample this cycle
//   io_out     registered output sample, holds when out_en = OUT_NONE
//   out_ch     channel tag of io_out
//   out_en     OUT_NONE / OUT_SAMPLE / OUT_FRAME_END (tag CH-1)
//   count      current FIFO occupancy
module procfix_sample_fifo
    import procfix_pkg::*;
#(
    parameter int DATA_W = 31,
    parameter int DEPTH  = 8,
    parameter int CH     = 2,
    parameter int CH_W   = ch_width(CH),
    parameter int AW     = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in,
    output logic [1:0]               req_in,
    input  logic                     rd_ready,
    output logic signed [DATA_W-1:0] io_out,
    output logic [CH_W-1:0]          out_ch,
    output logic [1:0]               out_en,
    output logic [CNT_W-1:0]         count
);

    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W+1)'(DEPTH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH - 1);

    logic                   req_q;   // request issued last cycle; its sample is on `in` now
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [CH_W-1:0]        wch;
    logic                   pop_q;   // a pop happened at the last edge
    logic                   push;
    logic                   pop;
    logic [CNT_W-1:0]       count_next;
    logic [CNT_W:0]         commit_next;
    logic [CH_W+DATA_W-1:0] rdata;

    assign push = req_q;
    // Pop only from stored entries, so a sample pushed into an empty FIFO is never popped at the same edge
    assign pop  = rd_ready && (count != '0);

    assign count_next  = count + CNT_W'(push) - CNT_W'(pop);
    // Occupancy after this edge plus the request still outstanding after it (today's req_in).
    // A new request is only issued if it still fits, so the FIFO can never overflow.
    assign commit_next = {1'b0, count_next} + (CNT_W+1)'(req_in == REQ_SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_in <= REQ_IDLE;
            req_q  <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            wch    <= '0;
            count  <= '0;
            pop_q  <= 1'b0;
        end else begin
            req_in <= (commit_next < DEPTH_V) ? REQ_SAMPLE : REQ_IDLE;
            req_q  <= (req_in == REQ_SAMPLE);
            if (push) begin
                wptr <= wptr + 1'b1;
                wch  <= (wch == LAST_CH) ? '0 : wch + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_next;
            pop_q <= pop;
        end
    end

    procfix_fifo_mem #(
        .WIDTH (CH_W + DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wptr),
        .wdata ({wch, in}),
        .re    (pop),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign io_out = $signed(rdata[DATA_W-1:0]);
    assign out_ch = rdata[CH_W+DATA_W-1:DATA_W];

    always_comb begin
        out_en = OUT_NONE;
        if (pop_q) begin
            out_en = (out_ch == LAST_CH) ? OUT_FRAME_END : OUT_SAMPLE;
        end
    end

endmodule

// File: tb/tb_procfix_sample_fifo.sv
// tb/tb_procfix_sample_fifo.sv - directed self-checking bench for procfix_sample_fifo
`timescale 1ns/1ps
module tb_procfix_sample_fifo;
    import procfix_pkg::*;

    localparam int DW = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: default parameters (DEPTH 8, CH 2)
    logic signed [DW-1:0] a_in;
    logic [1:0]           a_req;
    logic                 a_rdy;
    logic signed [DW-1:0] a_out;
    logic [0:0]           a_ch;
    logic [1:0]           a_en;
    logic [3:0]           a_cnt;

    // DUT B: DEPTH 4, CH 3
    logic signed [DW-1:0] b_in;
    logic [1:0]           b_req;
    logic                 b_rdy;
    logic signed [DW-1:0] b_out;
    logic [1:0]           b_ch;
    logic [1:0]           b_en;
    logic [2:0]           b_cnt;

    procfix_sample_fifo u_dut_a (
        .clk(clk), .rst(rst), .in(a_in), .req_in(a_req), .rd_ready(a_rdy),
        .io_out(a_out), .out_ch(a_ch), .out_en(a_en), .count(a_cnt)
    );

    procfix_sample_fifo #(.DATA_W(DW), .DEPTH(4), .CH(3)) u_dut_b (
        .clk(clk), .rst(rst), .in(b_in), .req_in(b_req), .rd_ready(b_rdy),
        .io_out(b_out), .out_ch(b_ch), .out_en(b_en), .count(b_cnt)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic signed [DW-1:0] a_src[$], b_src[$];
    logic signed [DW-1:0] a_out_q[$], b_out_q[$];
    int                   a_ch_q[$], b_ch_q[$];
    logic [1:0]           a_en_q[$], b_en_q[$];
    int a_sent, a_req_cnt, b_max_cnt;
    logic signed [DW-1:0] exp_v [100];

    // Source responder and output monitor for DUT A
    initial begin : a_agent
        logic pend;
        forever begin
            @(negedge clk);
            pend = !rst && (a_req == REQ_SAMPLE);
            if (!rst) begin
                if (a_req == REQ_SAMPLE) a_req_cnt++;
                if (a_en != OUT_NONE) begin
                    a_out_q.push_back(a_out);
                    a_ch_q.push_back(int'(a_ch));
                    a_en_q.push_back(a_en);
                end
            end
            @(posedge clk);
            #1;
            if (pend && !rst) begin
                a_sent++;
                if (a_src.size() > 0) a_in = a_src.pop_front();
                else a_in = '0;
            end
        end
    end

    // Source responder and output monitor for DUT B
    initial begin : b_agent
        logic pend;
        forever begin
            @(negedge clk);
            pend = !rst && (b_req == REQ_SAMPLE);
            if (!rst) begin
                if (int'(b_cnt) > b_max_cnt) b_max_cnt = int'(b_cnt);
                if (b_en != OUT_NONE) begin
                    b_out_q.push_back(b_out);
                    b_ch_q.push_back(int'(b_ch));
                    b_en_q.push_back(b_en);
                end
            end
            @(posedge clk);
            #1;
            if (pend && !rst) begin
                if (b_src.size() > 0) b_in = b_src.pop_front();
                else b_in = '0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        a_src.delete(); a_out_q.delete(); a_ch_q.delete(); a_en_q.delete();
        b_src.delete(); b_out_q.delete(); b_ch_q.delete(); b_en_q.delete();
        a_sent = 0; a_req_cnt = 0; b_max_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_req !== REQ_IDLE) begin tests_failed++; $display("FAIL reset_req: got %0d expected 0", a_req); end
        tests_run++;
        if (a_en !== OUT_NONE) begin tests_failed++; $display("FAIL reset_out_en: got %0d expected 0", a_en); end
        tests_run++;
        if (a_out !== '0) begin tests_failed++; $display("FAIL reset_io_out: got %0d expected 0", a_out); end
        tests_run++;
        if (a_ch !== 1'b0) begin tests_failed++; $display("FAIL reset_out_ch: got %0d expected 0", a_ch); end
        tests_run++;
        if (a_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", a_cnt); end
        do_reset();
        @(negedge clk);
        tests_run++;
        if (a_req !== REQ_SAMPLE) begin tests_failed++; $display("FAIL first_req: got %0d expected 1", a_req); end
    endtask

    task automatic test_fill();
        a_rdy = 1'b0;
        do_reset();
        for (int i = 1; i <= 20; i++) a_src.push_back(DW'(i));
        repeat (30) @(negedge clk);
        tests_run++;
        if (a_req_cnt !== 8) begin tests_failed++; $display("FAIL fill_req_pulses: got %0d expected 8", a_req_cnt); end
        tests_run++;
        if (a_cnt !== 4'd8) begin tests_failed++; $display("FAIL fill_count: got %0d expected 8", a_cnt); end
        tests_run++;
        if (a_req !== REQ_IDLE) begin tests_failed++; $display("FAIL fill_req_idle: got %0d expected 0", a_req); end
        tests_run++;
        if (a_sent !== 8) begin tests_failed++; $display("FAIL fill_sent: got %0d expected 8", a_sent); end
        tests_run++;
        if (a_out_q.size() !== 0) begin tests_failed++; $display("FAIL fill_no_output: got %0d expected 0", a_out_q.size()); end
    endtask

    task automatic test_drain();
        a_rdy = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++;
        if (a_out_q.size() < 16) begin tests_failed++; $display("FAIL drain_size: got %0d expected >= 16", a_out_q.size()); end
        for (int i = 0; i < 16 && i < a_out_q.size(); i++) begin
            tests_run++;
            if (int'(a_out_q[i]) !== i + 1 || a_ch_q[i] !== (i % 2) ||
                a_en_q[i] !== ((i % 2 == 1) ? OUT_FRAME_END : OUT_SAMPLE)) begin
                tests_failed++;
                $display("FAIL drain_item%0d: got data %0d ch %0d en %0d expected data %0d ch %0d en %0d",
                         i, a_out_q[i], a_ch_q[i], a_en_q[i], i + 1, i % 2, (i % 2 == 1) ? 2 : 1);
            end
        end
    endtask

    task automatic test_stream();
        int gaps;
        a_rdy = 1'b1;
        do_reset();
        exp_v[0] = DW'(-(2 ** 30));
        exp_v[1] = DW'((2 ** 30) - 1);
        for (int i = 2; i < 100; i++) exp_v[i] = (i % 2 == 1) ? DW'(i * 1234567) : DW'(-i * 7654321);
        for (int i = 0; i < 100; i++) a_src.push_back(exp_v[i]);
        gaps = 0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (a_req !== REQ_SAMPLE) gaps++;
            if (k >= 4 && a_en === OUT_NONE) gaps++;
        end
        tests_run++;
        if (gaps !== 0) begin tests_failed++; $display("FAIL stream_sustain: got %0d gap cycles expected 0", gaps); end
        tests_run++;
        if (a_out_q.size() < 100) begin tests_failed++; $display("FAIL stream_size: got %0d expected >= 100", a_out_q.size()); end
        for (int i = 0; i < 100 && i < a_out_q.size(); i++) begin
            tests_run++;
            if (a_out_q[i] !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL stream_item%0d: got %0d expected %0d", i, a_out_q[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_random_ch3();
        int n;
        b_rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) b_src.push_back(DW'(i * 3 - 50));
        n = 0;
        while (b_out_q.size() < 40 && n < 400) begin
            @(negedge clk);
            b_rdy = 1'($urandom_range(0, 1));
            n++;
        end
        b_rdy = 1'b0;
        tests_run++;
        if (b_out_q.size() < 40) begin tests_failed++; $display("FAIL rand_size: got %0d expected >= 40", b_out_q.size()); end
        for (int i = 0; i < 40 && i < b_out_q.size(); i++) begin
            tests_run++;
            if (int'(b_out_q[i]) !== i * 3 - 50 || b_ch_q[i] !== (i % 3) ||
                b_en_q[i] !== ((i % 3 == 2) ? OUT_FRAME_END : OUT_SAMPLE)) begin
                tests_failed++;
                $display("FAIL rand_item%0d: got data %0d ch %0d en %0d expected data %0d ch %0d en %0d",
                         i, b_out_q[i], b_ch_q[i], b_en_q[i], i * 3 - 50, i % 3, (i % 3 == 2) ? 2 : 1);
            end
        end
        tests_run++;
        if (b_max_cnt > 4) begin tests_failed++; $display("FAIL rand_max_count: got %0d expected <= 4", b_max_cnt); end
    endtask

    task automatic test_mid_reset();
        int n;
        a_rdy = 1'b0;
        do_reset();
        for (int i = 1; i <= 20; i++) a_src.push_back(DW'(i));
        n = 0;
        while (a_cnt !== 4'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (a_cnt !== 4'd5) begin tests_failed++; $display("FAIL midrst_reach5: got %0d expected 5", a_cnt); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (a_en !== OUT_NONE || a_req !== REQ_IDLE || a_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL midrst_async: got en %0d req %0d count %0d expected 0 0 0", a_en, a_req, a_cnt);
        end
        @(negedge clk);
        do_reset();
        for (int i = 100; i < 120; i++) a_src.push_back(DW'(i));
        a_rdy = 1'b1;
        n = 0;
        while (a_out_q.size() < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (a_out_q.size() < 2) begin
            tests_failed++;
            $display("FAIL midrst_restart: got %0d outputs expected >= 2", a_out_q.size());
        end else if (int'(a_out_q[0]) !== 100 || a_ch_q[0] !== 0 || int'(a_out_q[1]) !== 101 || a_ch_q[1] !== 1) begin
            tests_failed++;
            $display("FAIL midrst_restart: got %0d/%0d %0d/%0d expected 100/0 101/1",
                     a_out_q[0], a_ch_q[0], a_out_q[1], a_ch_q[1]);
        end
    endtask

    task automatic test_single();
        a_rdy = 1'b1;
        do_reset();
        a_src.push_back(DW'(42));
        a_src.push_back(DW'(43));
        @(negedge clk);
        tests_run++;
        if (a_en !== OUT_NONE) begin tests_failed++; $display("FAIL empty_no_pop: got %0d expected 0", a_en); end
        @(negedge clk);
        tests_run++;
        if (a_en !== OUT_NONE || a_cnt !== 4'd0) begin
            tests_failed++; $display("FAIL empty_idle: got en %0d count %0d expected 0 0", a_en, a_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (a_cnt !== 4'd1 || a_en !== OUT_NONE) begin
            tests_failed++; $display("FAIL single_no_fallthrough: got count %0d en %0d expected 1 0", a_cnt, a_en);
        end
        @(negedge clk);
        tests_run++;
        if (a_en !== OUT_SAMPLE || int'(a_out) !== 42 || a_ch !== 1'b0) begin
            tests_failed++; $display("FAIL single_out: got en %0d data %0d ch %0d expected 1 42 0", a_en, a_out, a_ch);
        end
        @(negedge clk);
        tests_run++;
        if (a_en !== OUT_FRAME_END || int'(a_out) !== 43 || a_ch !== 1'b1) begin
            tests_failed++; $display("FAIL single_next: got en %0d data %0d ch %0d expected 2 43 1", a_en, a_out, a_ch);
        end
    endtask

    initial begin
        a_in = '0; b_in = '0;
        a_rdy = 1'b0; b_rdy = 1'b0;
        a_sent = 0; a_req_cnt = 0; b_max_cnt = 0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_random_ch3();
        test_mid_reset();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/procfix_sample_fifo.md
PROCFIX_SAMPLE_FIFO -- requirements
Module: procfix_sample_fifo

Interface
REQ-001 Parameter DATA_W, default 31, width of signed fixed-point sample.
REQ-002 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter CH, default 2, interleaved channel count, minimum 1; CH_W = max(1, clog2(CH)).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in  input  DATA_W signed  sample from source, valid the cycle after req_in = 2'd1.
REQ-007 req_in  output  2  source request code: 2'd0 idle, 2'd1 request one sample; other codes SHALL never be driven.
REQ-008 rd_ready  input  1  downstream can accept one sample this cycle.
REQ-009 io_out  output  DATA_W signed  output sample, registered.
REQ-010 out_ch  output  CH_W  channel tag of io_out.
REQ-011 out_en  output  2  2'd0 none, 2'd1 sample valid, 2'd2 sample valid and last channel of frame (tag CH-1).
REQ-012 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 req_in is registered; req_in = 2'd1 in cycle t means in SHALL be captured at the rising edge ending cycle t+1.
REQ-014 inflight = number of requests issued but not yet captured (0..2); req_in SHALL be 2'd1 in the next cycle only if next count + next inflight < DEPTH.
REQ-015 With rd_ready held high and source always responding, req_in SHALL stay 2'd1 every cycle (one sample per cycle sustained).
REQ-016 Each captured sample SHALL be tagged with write-channel counter wch, then wch increments, wrapping CH-1 -> 0.
REQ-017 Pop occurs at an edge where rd_ready = 1 and count > 0; io_out/out_ch/out_en SHALL present the popped entry in the following cycle, for exactly one cycle.
REQ-018 out_en SHALL be 2'd2 when popped tag = CH-1, else 2'd1; 2'd0 in any cycle without a preceding pop.
REQ-019 io_out and out_ch SHALL hold their last value when out_en = 2'd0.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push into empty with pop in same edge SHALL not pop the new entry (no fall-through).
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; the FIFO SHALL never overflow by construction (no sample is ever dropped).
REQ-022 Empty: rd_ready = 1 SHALL produce no pop and out_en = 2'd0.
REQ-023 Data SHALL pass unmodified: bit-exact DATA_W signed, no rounding or saturation.

Reset
REQ-024 While rst = 1: req_in = 2'd0, out_en = 2'd0, io_out = 0, out_ch = 0, count = 0, pointers = 0, wch = 0, inflight = 0.
REQ-025 Reset mid-operation SHALL discard buffered and in-flight samples; a sample the source presents in the first cycle after rst deasserts SHALL not be captured.
REQ-026 First req_in = 2'd1 SHALL appear in the first cycle after the first rising edge with rst = 0.

Structure
REQ-027 Shared package procfix_pkg SHALL hold REQ_IDLE = 2'd0, REQ_SAMPLE = 2'd1, OUT_NONE = 2'd0, OUT_SAMPLE = 2'd1, OUT_FRAME_END = 2'd2.
REQ-028 Storage SHALL be one sub-module procfix_fifo_mem (DEPTH x (CH_W+DATA_W), one synchronous write port, one synchronous read port); control stays in procfix_sample_fifo.

Verification
REQ-029 Reset then rd_ready = 0, source answers every request with 1,2,3,... -> exactly 8 req_in pulses, count = 8, req_in = 2'd0 thereafter, no sample lost.
REQ-030 Then rd_ready = 1 -> out_en sequence 1,2,1,2,... with io_out 1..8, out_ch 0,1,0,1,...; count reaches 0, requests resume.
REQ-031 rd_ready = 1 continuously, 100 samples including -2^30 and 2^30-1 -> one output per cycle after fill, bit-exact, in order, req_in held 2'd1.
REQ-032 rd_ready toggled random 50%, CH = 3, DEPTH = 4 -> output equals input order, out_en = 2'd2 exactly on tag 2, count never > 4.
REQ-033 Assert rst for 1 cycle while count = 5 with one request in flight -> all outputs 2'd0 and count = 0 immediately; post-reset stream starts from first new sample with tag 0.
REQ-034 Empty FIFO, rd_ready = 1, single sample 42 pushed -> out_en = 2'd1, io_out = 42 exactly two cycles after capture edge, then out_en = 2'd0.
